// File: rtl/coax_rx_buffer.sv
// Receive-side word FIFO behind coax_rx: first-word-fall-through storage of decoded words,
// plus sticky error/overflow status and an end-of-frame pulse for the host.
module coax_rx_buffer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DEPTH_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          rx_data,
    input  logic                rx_strobe,
    input  logic                rx_error,
    input  logic                rx_active,
    input  logic                clear,
    input  logic                read_strobe,
    output logic [9:0]          data,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_BITS:0] count,
    output logic                error,
    output logic [9:0]          error_code,
    output logic                overflow,
    output logic                frame_done
);

    localparam logic [DEPTH_BITS:0]   PTR_ONE = (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS-1:0] IDX_ONE = DEPTH_BITS'(1);

    logic [9:0]            mem [DEPTH];
    logic [DEPTH_BITS:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_BITS-1:0] wr_idx, rd_idx, rd_idx_inc;
    logic [9:0]            data_q, data_d;
    logic                  error_q, overflow_q, frame_done_q, rx_active_q;
    logic [9:0]            error_code_q;
    logic                  push, pop, we, drop, frame_done_d;

    assign wr_idx     = wr_ptr_q[DEPTH_BITS-1:0];
    assign rd_idx     = rd_ptr_q[DEPTH_BITS-1:0];
    assign rd_idx_inc = rd_idx + IDX_ONE;

    // Extra wrap bit distinguishes full from empty when the indices coincide.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) && (wr_idx == rd_idx);
    assign count = wr_ptr_q - rd_ptr_q;

    assign pop  = read_strobe & ~empty & ~clear;
    assign push = rx_strobe & ~rx_error & ~error_q & ~clear;
    assign we   = push & (~full | pop);
    assign drop = push & full & ~pop;

    assign frame_done_d = rx_active_q & ~rx_active & (count != '0) & ~error_q & ~clear;

    // Head register: loads the word that will sit at the read pointer after this edge.
    always_comb begin
        data_d = data_q;
        if (pop) begin
            if (count == PTR_ONE) begin
                if (we) begin
                    data_d = rx_data;
                end
            end else begin
                data_d = mem[rd_idx_inc];
            end
        end else if (we && empty) begin
            data_d = rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_q       <= '0;
            error_q      <= 1'b0;
            error_code_q <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            rx_active_q  <= 1'b0;
        end else begin
            rx_active_q <= rx_active;
            data_q      <= data_d;
            if (clear) begin
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                error_q      <= 1'b0;
                error_code_q <= '0;
                overflow_q   <= 1'b0;
                frame_done_q <= 1'b0;
            end else begin
                if (we) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
                if (rx_error && !error_q) begin
                    error_q      <= 1'b1;
                    error_code_q <= rx_data;
                end
                frame_done_q <= frame_done_d;
            end
        end
    end

    assign data       = data_q;
    assign error      = error_q;
    assign error_code = error_code_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Self-checking bench for coax_rx_buffer: directed scenarios plus randomized traffic
// compared against a queue-based model of the receive buffer.
module tb_coax_rx_buffer;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] rx_data;
    logic       rx_strobe, rx_error, rx_active, clear, read_strobe;
    logic [9:0] data;
    logic       empty, full;
    logic [4:0] count;
    logic       error;
    logic [9:0] error_code;
    logic       overflow, frame_done;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [9:0] q[$];
    logic       m_err, m_ovf, m_fd, m_act_prev;
    logic [9:0] m_code;

    coax_rx_buffer #(.DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_strobe  (rx_strobe),
        .rx_error   (rx_error),
        .rx_active  (rx_active),
        .clear      (clear),
        .read_strobe(read_strobe),
        .data       (data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .error      (error),
        .error_code (error_code),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_err = 1'b0; m_ovf = 1'b0; m_fd = 1'b0; m_act_prev = 1'b0; m_code = '0;
    endtask

    // Drive one cycle of stimulus, advance the model, then sample 1 time unit after the edge.
    task automatic step(input logic s, input logic [9:0] d, input logic e, input logic r,
                        input logic a, input logic c);
        logic do_pop, do_push;
        rx_strobe = s; rx_data = d; rx_error = e; read_strobe = r; rx_active = a; clear = c;
        if (c) begin
            q.delete();
            m_err = 1'b0; m_code = '0; m_ovf = 1'b0; m_fd = 1'b0;
        end else begin
            do_pop  = r && (q.size() > 0);
            do_push = s && !e && !m_err;
            m_fd    = m_act_prev && !a && (q.size() > 0) && !m_err;
            if (e && !m_err) begin
                m_err  = 1'b1;
                m_code = d;
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < D) q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        m_act_prev = a;
        @(posedge clk);
        #1;
        rx_strobe = 1'b0; rx_error = 1'b0; read_strobe = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || data !== 10'd0) begin
            bad++;
            $display("FAIL reset_fifo: empty=%b full=%b count=%0d data=%h, want 1 0 0 000",
                     empty, full, count, data);
        end
        total++;
        if (error !== 1'b0 || error_code !== 10'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: err=%b code=%h ovf=%b fd=%b, want all 0",
                     error, error_code, overflow, frame_done);
        end
    endtask

    task automatic test_basic();
        step(1, 10'h175, 0, 0, 0, 0);
        step(1, 10'h28A, 0, 0, 0, 0);
        total++;
        if (count !== 5'd2 || data !== 10'h175) begin
            bad++;
            $display("FAIL basic_push: count=%0d data=%h, want 2 175", count, data);
        end
        step(0, 0, 0, 1, 0, 0);
        total++;
        if (data !== 10'h28A || count !== 5'd1) begin
            bad++;
            $display("FAIL basic_pop1: count=%0d data=%h, want 1 28a", count, data);
        end
        step(0, 0, 0, 1, 0, 0);
        total++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            bad++;
            $display("FAIL basic_pop2: empty=%b count=%0d, want 1 0", empty, count);
        end
        step(0, 0, 0, 1, 0, 0);
        total++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            bad++;
            $display("FAIL pop_empty: empty=%b count=%0d, want 1 0", empty, count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= D; i++) step(1, 10'(i), 0, 0, 0, 0);
        total++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL fill: full=%b count=%0d ovf=%b, want 1 16 0", full, count, overflow);
        end
        step(1, 10'h3FF, 0, 0, 0, 0);
        total++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            bad++;
            $display("FAIL overflow: ovf=%b count=%0d, want 1 16", overflow, count);
        end
        for (int i = 1; i <= D; i++) begin
            total++;
            if (data !== 10'(i)) begin
                bad++;
                $display("FAIL drain_order: idx=%0d data=%h, want %h", i, data, 10'(i));
            end
            step(0, 0, 0, 1, 0, 0);
        end
        total++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL drain_end: empty=%b ovf=%b, want 1 1", empty, overflow);
        end
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_full_push_pop();
        logic [9:0] last;
        for (int i = 0; i < D; i++) step(1, 10'h200 + 10'(i), 0, 0, 0, 0);
        step(1, 10'h155, 0, 1, 0, 0);
        total++;
        if (count !== 5'd16 || overflow !== 1'b0 || data !== 10'h201) begin
            bad++;
            $display("FAIL full_push_pop: count=%0d ovf=%b data=%h, want 16 0 201",
                     count, overflow, data);
        end
        last = '0;
        for (int i = 0; i < D; i++) begin
            last = data;
            step(0, 0, 0, 1, 0, 0);
        end
        total++;
        if (last !== 10'h155 || empty !== 1'b1) begin
            bad++;
            $display("FAIL full_last: last=%h empty=%b, want 155 1", last, empty);
        end
    endtask

    task automatic test_error();
        step(1, 10'h031, 0, 0, 0, 0);
        step(0, 10'h002, 1, 0, 0, 0);
        total++;
        if (error !== 1'b1 || error_code !== 10'h002) begin
            bad++;
            $display("FAIL err_capture: err=%b code=%h, want 1 002", error, error_code);
        end
        step(0, 10'h077, 1, 0, 0, 0);
        step(1, 10'h100, 0, 0, 0, 0);
        total++;
        if (count !== 5'd1 || data !== 10'h031 || error_code !== 10'h002) begin
            bad++;
            $display("FAIL err_block: count=%0d data=%h code=%h, want 1 031 002",
                     count, data, error_code);
        end
        step(0, 0, 0, 0, 0, 1);
        total++;
        if (error !== 1'b0 || empty !== 1'b1 || error_code !== 10'd0) begin
            bad++;
            $display("FAIL err_clear: err=%b empty=%b code=%h, want 0 1 000",
                     error, empty, error_code);
        end
    endtask

    task automatic test_frame_done();
        int pulses;
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 10'h0A0 + 10'(i), 0, 0, 1, 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (frame_done === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL frame_done_pulse: high_cycles=%0d, want 1", pulses);
        end
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (frame_done !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL frame_done_empty: high_cycles=%0d, want 0", pulses);
        end
    endtask

    task automatic test_wrap();
        int next_exp;
        int errs;
        next_exp = 0;
        errs = 0;
        for (int i = 0; i < 36; i++) begin
            if (!empty && i >= 3) begin
                if (data !== 10'h040 + 10'(next_exp)) errs++;
                next_exp++;
                step(1, 10'h040 + 10'(i), 0, 1, 0, 0);
            end else begin
                step(1, 10'h040 + 10'(i), 0, 0, 0, 0);
            end
        end
        while (!empty && next_exp < 40) begin
            if (data !== 10'h040 + 10'(next_exp)) errs++;
            next_exp++;
            step(0, 0, 0, 1, 0, 0);
        end
        total++;
        if (errs != 0 || next_exp != 36 || empty !== 1'b1) begin
            bad++;
            $display("FAIL wrap_order: errors=%0d read=%0d empty=%b, want 0 36 1",
                     errs, next_exp, empty);
        end
    endtask

    task automatic test_random();
        logic a;
        int errs;
        a = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) a = ~a;
            step($urandom_range(0, 2) != 0, 10'($urandom), $urandom_range(0, 63) == 0,
                 $urandom_range(0, 2) == 0, a, $urandom_range(0, 79) == 0);
            errs = 0;
            if (count !== 5'(q.size())) errs++;
            if (empty !== (q.size() == 0)) errs++;
            if (full !== (q.size() == D)) errs++;
            if (q.size() > 0 && data !== q[0]) errs++;
            if (error !== m_err || error_code !== m_code || overflow !== m_ovf) errs++;
            if (frame_done !== m_fd) errs++;
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL random_cycle%0d: count=%0d data=%h err=%b code=%h ovf=%b fd=%b, want %0d %h %b %h %b %b",
                         n, count, data, error, error_code, overflow, frame_done,
                         q.size(), (q.size() > 0) ? q[0] : data, m_err, m_code, m_ovf, m_fd);
            end
        end
    endtask

    task automatic test_async_reset();
        rx_active = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 10'h300 + 10'(i), 0, i[0], 0, 0);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (empty !== 1'b1 || count !== 5'd0 || data !== 10'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: empty=%b count=%0d data=%h ovf=%b, want 1 0 000 0",
                     empty, count, data, overflow);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(1, 10'h123, 0, 0, 0, 0);
        total++;
        if (count !== 5'd1 || data !== 10'h123) begin
            bad++;
            $display("FAIL after_reset: count=%0d data=%h, want 1 123", count, data);
        end
    endtask

    initial begin
        reset = 1'b0;
        rx_data = '0; rx_strobe = 1'b0; rx_error = 1'b0; rx_active = 1'b0;
        clear = 1'b0; read_strobe = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_error();
        test_frame_done();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
